vreg_read_responder: RTL

Responder end of the operand read-address stream: accepts `addr_t` read addresses one per handshake, reads an internal vector register file, and packs four consecutive results (vrs1, vrs2, vrs3, vrs3+1 order) into one operand bundle. The bundle is offered downstream on a valid/ready handshake. The block sits between the micro-instruction address sequencer and the execution datapath, and owns the register file write port.

---
 rtl/vreg_read_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/vreg_read_responder.sv
// Operand read responder: collects four register reads into one bundle and holds it until downstream accepts.
// Optional macro VREG_RD_BYPASS_EN enables write-first forwarding of a same-edge write to the read slot.
module vreg_read_responder #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64
) (
  input  logic                clk_i,
  input  logic                arst_ni,
  input  logic [ADDR_W-1:0]   rd_addr_i,
  input  logic                rd_addr_valid_i,
  output logic                rd_addr_ready_o,
  input  logic                wr_en_i,
  input  logic [ADDR_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  output logic [4*DATA_W-1:0] operands_o,
  output logic                operands_valid_o,
  input  logic                operands_ready_i,
  output logic                rd_err_o
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef enum logic {COLLECT, HOLD} state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic              rd_err;
  logic [DATA_W-1:0] regs  [NUM_REGS];
  logic [DATA_W-1:0] slots [4];

  logic              rd_in_range;
  logic              wr_in_range;
  logic [IDX_W-1:0]  rd_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] rd_data;

  // One extra bit keeps the compare exact when NUM_REGS == 2**ADDR_W.
  assign rd_in_range = ({1'b0, addr_t'(rd_addr_i)} < (ADDR_W+1)'(NUM_REGS));
  assign wr_in_range = ({1'b0, addr_t'(wr_addr_i)} < (ADDR_W+1)'(NUM_REGS));
  assign rd_idx      = rd_addr_i[IDX_W-1:0];
  assign wr_idx      = wr_addr_i[IDX_W-1:0];

  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
`ifdef VREG_RD_BYPASS_EN
      if (wr_en_i && (wr_addr_i == rd_addr_i))
        rd_data = wr_data_i;
      else
        rd_data = regs[rd_idx];
`else
      rd_data = regs[rd_idx];
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state  <= COLLECT;
      cnt    <= 2'd0;
      rd_err <= 1'b0;
      for (int i = 0; i < 4; i++) slots[i] <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (wr_en_i && wr_in_range)
        regs[wr_idx] <= wr_data_i;
      case (state)
        COLLECT: begin
          if (rd_addr_valid_i) begin
            slots[cnt] <= rd_data;
            if (!rd_in_range) rd_err <= 1'b1;
            cnt <= cnt + 2'd1;
            if (cnt == 2'd3) state <= HOLD;
          end
        end
        HOLD: begin
          if (operands_ready_i) state <= COLLECT;
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign rd_addr_ready_o  = (state == COLLECT);
  assign operands_valid_o = (state == HOLD);
  assign rd_err_o         = rd_err;

  always_comb begin
    operands_o = '0;
    for (int k = 0; k < 4; k++)
      operands_o[k*DATA_W +: DATA_W] = slots[k];
  end

endmodule
